// File: rtl/ps_window_linebuf_if.sv
// Handshake bundle between the pixel source/window consumer and ps_window_linebuf.
// The master side drives requests and write data; the slave side returns the window and status.
interface ps_window_linebuf_if #(
  parameter int LINE_LENGTH = 640,
  parameter int DATA_WIDTH  = 8,
  parameter int TAPS        = 3
);
  localparam int CW = $clog2(LINE_LENGTH + 1);

  logic                       i_flush;
  logic                       i_wr;
  logic [DATA_WIDTH-1:0]      i_wdata;
  logic                       i_rd;
  logic [TAPS*DATA_WIDTH-1:0] o_rdata;
  logic                       o_rvalid;
  logic [CW-1:0]              o_count;
  logic                       o_full;
  logic                       o_empty;

  modport master (
    output i_flush, i_wr, i_wdata, i_rd,
    input  o_rdata, o_rvalid, o_count, o_full, o_empty
  );

  modport slave (
    input  i_flush, i_wr, i_wdata, i_rd,
    output o_rdata, o_rvalid, o_count, o_full, o_empty
  );
endinterface

// File: rtl/ps_window_linebuf.sv
// Single-line pixel buffer returning a TAPS-wide horizontal window per read, with
// zero-pad or edge-replicate handling at the line ends instead of wrap-around.
module ps_window_linebuf #(
  parameter int LINE_LENGTH = 640,
  parameter int DATA_WIDTH  = 8,
  parameter int TAPS        = 3,
  parameter int EDGE_MODE   = 1
) (
  input logic i_clk,
  input logic i_rst,
  ps_window_linebuf_if.slave bus
);
  localparam int  H    = (TAPS - 1) / 2;
  localparam int  CW   = $clog2(LINE_LENGTH + 1);
  localparam int  AW   = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic EDGE = (EDGE_MODE != 0);

  logic [DATA_WIDTH-1:0]      mem [LINE_LENGTH];
  logic [AW-1:0]              wptr, rptr;
  logic [CW-1:0]              count, count_nxt, rem, need;
  logic                       full, empty;
  logic                       wr_ok, rd_ok;
  logic [TAPS*DATA_WIDTH-1:0] window_p0;
  logic [TAPS*DATA_WIDTH-1:0] rdata_p1;
  logic                       vld_p1;

  // Taps past either end of the line never wrap into the other end.
  function automatic logic [DATA_WIDTH-1:0] tap_at(input int idx);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    if (idx < 0)
      tap_at = EDGE ? mem[0] : '0;
    else if (idx > LINE_LENGTH - 1)
      tap_at = EDGE ? mem[LINE_LENGTH-1] : '0;
    else
      tap_at = mem[a];
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == AW'(LINE_LENGTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A read needs every in-line tap right of centre already written.
  always_comb begin
    rem  = CW'(LINE_LENGTH - 1) - CW'(rptr);
    need = (rem < CW'(H)) ? rem : CW'(H);
  end

  assign rd_ok = bus.i_rd & (count > need) & ~bus.i_flush;
  assign wr_ok = bus.i_wr & (~full | rd_ok) & ~bus.i_flush;

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)
      count_nxt = count + CW'(1);
    else if (rd_ok && !wr_ok)
      count_nxt = count - CW'(1);
  end

  // Stage p0: asynchronous tap mux, MSB slice holds rptr-H.
  always_comb begin
    window_p0 = '0;
    for (int j = 0; j < TAPS; j++)
      window_p0[(TAPS-1-j)*DATA_WIDTH +: DATA_WIDTH] = tap_at(int'(rptr) + j - H);
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok)
      mem[wptr] <= bus.i_wdata;
  end

  // Stage p1: output register; flush leaves the last window in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else if (bus.i_flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      vld_p1 <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= ptr_inc(wptr);
      if (rd_ok) begin
        rptr     <= ptr_inc(rptr);
        rdata_p1 <= window_p0;
      end
      vld_p1 <= rd_ok;
      count  <= count_nxt;
      full   <= (count_nxt == CW'(LINE_LENGTH));
      empty  <= (count_nxt == '0);
    end
  end

  assign bus.o_rdata  = rdata_p1;
  assign bus.o_rvalid = vld_p1;
  assign bus.o_count  = count;
  assign bus.o_full   = full;
  assign bus.o_empty  = empty;
endmodule
